// File: rtl/enreg_bank_write_arbiter_if.sv
// Write-request bundle shared by NUM_REQ requesters and the bank write arbiter.
// Handshake: req[i] is valid and gnt[i] is ready; a write transfers on the clock edge where
// req[i] & gnt[i] is high. Until that edge the requester holds req[i] and its address/data slices stable.
interface enreg_bank_write_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int AW      = 3,
  parameter int DATA_W  = 4
);
  logic [NUM_REQ-1:0]        req;
  logic [NUM_REQ*AW-1:0]     wr_addr;
  logic [NUM_REQ*DATA_W-1:0] wr_data;
  logic [NUM_REQ-1:0]        gnt;

  modport master (output req, output wr_addr, output wr_data, input gnt);
  modport slave  (input req, input wr_addr, input wr_data, output gnt);
endinterface

// File: rtl/enreg_bank_write_arbiter.sv
// Round-robin write arbiter and sole writer of a register bank, with a one-entry-per-cycle
// clear sweep and a combinational read port.
module enreg_bank_write_arbiter #(
  parameter int NUM_REQ  = 4,
  parameter int NUM_REGS = 8,
  parameter int DATA_W   = 4,
  parameter int AW       = $clog2(NUM_REGS)
) (
  input  logic                      clk,
  input  logic                      reset_n,
  enreg_bank_write_arbiter_if.slave wr,
  input  logic                      clr_start,
  output logic                      clr_busy,
  output logic                      clr_done,
  input  logic [AW-1:0]             rd_addr,
  output logic [DATA_W-1:0]         rd_data,
  output logic                      dbg_state
);
  localparam int PW = $clog2(NUM_REQ);
  localparam logic [AW-1:0] LAST_IDX = AW'(NUM_REGS - 1);

  typedef enum logic {IDLE = 1'b0, CLEAR = 1'b1} state_e;

  state_e            state_q, state_d;
  logic [PW-1:0]     rr_ptr_q, rr_ptr_d;
  logic [AW-1:0]     idx_q, idx_d;
  logic              clr_done_q, clr_done_d;
  logic [DATA_W-1:0] regs_q [NUM_REGS];
  logic [DATA_W-1:0] regs_d [NUM_REGS];

  logic              win_vld;
  logic [PW-1:0]     win;
  logic [AW-1:0]     win_addr;
  logic [DATA_W-1:0] win_data;
  logic              arb_en;

  // Search upward from rr_ptr with wrap; the first requesting index found is the winner.
  always_comb begin
    int            cand;
    logic [PW-1:0] cand_p;
    win_vld = 1'b0;
    win     = '0;
    cand    = 0;
    cand_p  = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = int'(rr_ptr_q) + k;
      if (cand >= NUM_REQ) cand = cand - NUM_REQ;
      cand_p = PW'(cand);
      if (!win_vld && wr.req[cand_p]) begin
        win_vld = 1'b1;
        win     = cand_p;
      end
    end
  end

  always_comb begin
    win_addr = '0;
    win_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (win == PW'(i)) begin
        win_addr = wr.wr_addr[i*AW +: AW];
        win_data = wr.wr_data[i*DATA_W +: DATA_W];
      end
    end
  end

  // A pending clr_start suppresses every grant in the same cycle.
  assign arb_en = reset_n && (state_q == IDLE) && !clr_start;

  always_comb begin
    wr.gnt = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      wr.gnt[i] = arb_en && win_vld && (win == PW'(i));
    end
  end

  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    idx_d      = idx_q;
    clr_done_d = 1'b0;
    regs_d     = regs_q;
    case (state_q)
      IDLE: begin
        if (clr_start) begin
          state_d = CLEAR;
        end else if (win_vld) begin
          rr_ptr_d = (win == PW'(NUM_REQ - 1)) ? '0 : win + 1'b1;
          // Out-of-range addresses match no entry, so the data is dropped after the handshake.
          for (int r = 0; r < NUM_REGS; r++) begin
            if (win_addr == AW'(r)) regs_d[r] = win_data;
          end
        end
      end
      CLEAR: begin
        for (int r = 0; r < NUM_REGS; r++) begin
          if (idx_q == AW'(r)) regs_d[r] = '0;
        end
        if (idx_q == LAST_IDX) begin
          state_d    = IDLE;
          idx_d      = '0;
          clr_done_d = 1'b1;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      rr_ptr_q   <= '0;
      idx_q      <= '0;
      clr_done_q <= 1'b0;
      for (int r = 0; r < NUM_REGS; r++) regs_q[r] <= '0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      idx_q      <= idx_d;
      clr_done_q <= clr_done_d;
      regs_q     <= regs_d;
    end
  end

  always_comb begin
    rd_data = '0;
    for (int r = 0; r < NUM_REGS; r++) begin
      if (rd_addr == AW'(r)) rd_data = regs_q[r];
    end
  end

  assign clr_busy  = (state_q == CLEAR);
  assign clr_done  = clr_done_q;
  assign dbg_state = state_q;
endmodule

// File: tb/tb_enreg_bank_write_arbiter.sv
// Bench for enreg_bank_write_arbiter: directed vector table, clear/reset sequences, a 6-entry
// bank for address boundaries, and random traffic against a behavioural model of the bank.
module tb_enreg_bank_write_arbiter;
  localparam int NUM_REQ = 4;
  localparam int NUM_REGS = 8;
  localparam int DATA_W = 4;
  localparam int AW = 3;
  localparam int B_REGS = 6;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #20 clk = ~clk;

  logic              clr_start, clr_busy, clr_done, dbg_state;
  logic [AW-1:0]     rd_addr;
  logic [DATA_W-1:0] rd_data;
  logic              b_clr_start, b_clr_busy, b_clr_done, b_dbg_state;
  logic [AW-1:0]     b_rd_addr;
  logic [DATA_W-1:0] b_rd_data;

  enreg_bank_write_arbiter_if #(.NUM_REQ(NUM_REQ), .AW(AW), .DATA_W(DATA_W)) m_if ();
  enreg_bank_write_arbiter_if #(.NUM_REQ(NUM_REQ), .AW(AW), .DATA_W(DATA_W)) b_if ();

  enreg_bank_write_arbiter #(.NUM_REQ(NUM_REQ), .NUM_REGS(NUM_REGS), .DATA_W(DATA_W), .AW(AW)) dut (
    .clk(clk), .reset_n(reset_n), .wr(m_if), .clr_start(clr_start), .clr_busy(clr_busy),
    .clr_done(clr_done), .rd_addr(rd_addr), .rd_data(rd_data), .dbg_state(dbg_state));

  enreg_bank_write_arbiter #(.NUM_REQ(NUM_REQ), .NUM_REGS(B_REGS), .DATA_W(DATA_W), .AW(AW)) dut_b (
    .clk(clk), .reset_n(reset_n), .wr(b_if), .clr_start(b_clr_start), .clr_busy(b_clr_busy),
    .clr_done(b_clr_done), .rd_addr(b_rd_addr), .rd_data(b_rd_data), .dbg_state(b_dbg_state));

  int n_tests = 0;
  int n_fail = 0;
  logic [DATA_W-1:0] exp_q[$];

  // Behavioural model of the main bank.
  int m_regs[NUM_REGS];
  int m_ptr;
  bit m_busy;
  int m_idx;
  bit m_done;

  typedef struct {
    logic [NUM_REQ-1:0] req;
    logic [NUM_REQ-1:0] gnt;
  } vec_t;
  vec_t tbl[10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int r = 0; r < NUM_REGS; r++) m_regs[r] = 0;
    m_ptr = 0; m_busy = 0; m_idx = 0; m_done = 0;
  endtask

  function automatic int model_winner();
    int i;
    if (!reset_n || m_busy || clr_start) return -1;
    for (int k = 0; k < NUM_REQ; k++) begin
      i = (m_ptr + k) % NUM_REQ;
      if (m_if.req[i]) return i;
    end
    return -1;
  endfunction

  function automatic logic [NUM_REQ-1:0] model_gnt();
    logic [NUM_REQ-1:0] g;
    int w;
    g = '0;
    w = model_winner();
    if (w >= 0) g[w] = 1'b1;
    return g;
  endfunction

  task automatic model_edge();
    int w, a;
    bit done_next;
    if (!reset_n) begin
      model_reset();
      return;
    end
    w = model_winner();
    done_next = 0;
    if (m_busy) begin
      m_regs[m_idx] = 0;
      if (m_idx == NUM_REGS - 1) begin
        m_busy = 0; m_idx = 0; done_next = 1;
      end else begin
        m_idx++;
      end
    end else if (clr_start) begin
      m_busy = 1;
    end else if (w >= 0) begin
      a = int'(m_if.wr_addr[w*AW +: AW]);
      if (a < NUM_REGS) m_regs[a] = int'(m_if.wr_data[w*DATA_W +: DATA_W]);
      m_ptr = (w + 1) % NUM_REQ;
    end
    m_done = done_next;
  endtask

  task automatic sample_check();
    @(negedge clk);
    check("gnt", 32'(m_if.gnt), 32'(model_gnt()));
    check("clr_busy", 32'(clr_busy), 32'(m_busy));
    check("clr_done", 32'(clr_done), 32'(m_done));
    check("rd_data", 32'(rd_data), 32'(m_regs[rd_addr]));
  endtask

  task automatic advance();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic check_all_regs(input string name, input bit zero);
    for (int a = 0; a < NUM_REGS; a++) begin
      rd_addr = AW'(a);
      #1;
      check(name, 32'(rd_data), zero ? 32'd0 : 32'(m_regs[a]));
    end
    rd_addr = '0;
  endtask

  initial begin
    #1_000_000;
    n_fail++;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    tbl[0] = '{4'hF, 4'b0001}; tbl[1] = '{4'hF, 4'b0010};
    tbl[2] = '{4'hF, 4'b0100}; tbl[3] = '{4'hF, 4'b1000};
    tbl[4] = '{4'hF, 4'b0001}; tbl[5] = '{4'hF, 4'b0010};
    tbl[6] = '{4'hF, 4'b0100}; tbl[7] = '{4'h5, 4'b0001};
    tbl[8] = '{4'h5, 4'b0100}; tbl[9] = '{4'h0, 4'b0000};

    m_if.req = '0; m_if.wr_addr = '0; m_if.wr_data = '0;
    b_if.req = '0; b_if.wr_addr = '0; b_if.wr_data = '0;
    clr_start = 1'b0; rd_addr = '0; b_clr_start = 1'b0; b_rd_addr = '0;
    model_reset();

    // Reset held with all requests active.
    m_if.req = 4'hF;
    m_if.wr_addr = {3'd3, 3'd2, 3'd1, 3'd0};
    m_if.wr_data = {4'h4, 4'h3, 4'h2, 4'h1};
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    check("rst_gnt", 32'(m_if.gnt), 32'd0);
    check("rst_busy", 32'(clr_busy), 32'd0);
    check("rst_done", 32'(clr_done), 32'd0);
    check_all_regs("rst_regs", 1'b1);
    @(posedge clk);
    #1;
    reset_n = 1'b1;

    // Round-robin and wrap vectors.
    for (int r = 0; r < 10; r++) begin
      m_if.req = tbl[r].req;
      sample_check();
      check("rr_gnt", 32'(m_if.gnt), 32'(tbl[r].gnt));
      advance();
    end
    for (int a = 0; a < NUM_REQ; a++) exp_q.push_back(DATA_W'(a + 1));
    for (int a = 0; a < NUM_REQ; a++) begin
      rd_addr = AW'(a);
      sample_check();
      check("rd_back", 32'(rd_data), 32'(exp_q.pop_front()));
      advance();
    end

    // Fill with 4'hA, then clear while requester 1 waits.
    for (int a = 0; a < NUM_REGS; a++) begin
      m_if.req = 4'b0001;
      m_if.wr_addr = 12'(a);
      m_if.wr_data = 16'hA;
      sample_check();
      check("fill_gnt", 32'(m_if.gnt), 32'b0001);
      advance();
    end
    check_all_regs("fill_regs", 1'b0);
    m_if.req = 4'b0010;
    m_if.wr_addr = 12'(6) << AW;
    m_if.wr_data = 16'h7 << DATA_W;
    for (int c = 0; c <= NUM_REGS + 1; c++) begin
      clr_start = (c == 0);
      sample_check();
      if (c <= NUM_REGS) check("clr_gnt0", 32'(m_if.gnt), 32'd0);
      check("clr_busy_win", 32'(clr_busy), 32'(c >= 1 && c <= NUM_REGS));
      check("clr_done_win", 32'(clr_done), 32'(c == NUM_REGS + 1));
      if (c == NUM_REGS + 1) begin
        check("clr_then_gnt1", 32'(m_if.gnt), 32'b0010);
        check_all_regs("clr_regs", 1'b1);
      end
      advance();
    end
    clr_start = 1'b0;
    m_if.req = '0;

    // Refill, start a sweep, then reset at sweep index 3.
    for (int a = 0; a < NUM_REGS; a++) begin
      m_if.req = 4'b0001;
      m_if.wr_addr = 12'(a);
      m_if.wr_data = 16'(a + 1);
      sample_check();
      advance();
    end
    m_if.req = '0;
    for (int c = 0; c < 4; c++) begin
      clr_start = (c == 0);
      sample_check();
      advance();
    end
    clr_start = 1'b0;
    check("mid_busy_before", 32'(clr_busy), 32'd1);
    reset_n = 1'b0;
    #1;
    model_reset();
    check("mid_busy", 32'(clr_busy), 32'd0);
    check_all_regs("mid_regs", 1'b1);
    repeat (2) begin
      sample_check();
      advance();
    end
    reset_n = 1'b1;
    m_if.req = 4'hF;
    m_if.wr_addr = {3'd7, 3'd6, 3'd5, 3'd4};
    m_if.wr_data = {4'hD, 4'hC, 4'hB, 4'hE};
    for (int c = 0; c < NUM_REGS + 2; c++) begin
      sample_check();
      check("post_rst_done", 32'(clr_done), 32'd0);
      if (c == 0) check("post_rst_gnt", 32'(m_if.gnt), 32'b0001);
      advance();
    end
    m_if.req = '0;

    // Six-entry bank: out-of-range write and same-address ordering.
    b_if.req = 4'b0001;
    b_if.wr_addr = 12'(5);
    b_if.wr_data = 16'h9;
    sample_check();
    check("b_gnt_a5", 32'(b_if.gnt), 32'b0001);
    advance();
    b_if.req = 4'b0010;
    b_if.wr_addr = 12'(7) << AW;
    b_if.wr_data = 16'hF << DATA_W;
    sample_check();
    check("b_gnt_a7", 32'(b_if.gnt), 32'b0010);
    advance();
    b_if.req = '0;
    for (int a = 0; a < 8; a++) begin
      b_rd_addr = AW'(a);
      #1;
      check("b_regs", 32'(b_rd_data), (a == 5) ? 32'h9 : 32'h0);
    end
    b_if.req = 4'b0011;
    b_if.wr_addr = {3'd0, 3'd0, 3'd2, 3'd2};
    b_if.wr_data = {4'h0, 4'h0, 4'h5, 4'h3};
    sample_check();
    check("b_same_first", 32'(b_if.gnt), 32'b0001);
    advance();
    b_if.req = 4'b0010;
    sample_check();
    check("b_same_second", 32'(b_if.gnt), 32'b0010);
    advance();
    b_if.req = '0;
    b_rd_addr = 3'd2;
    #1;
    check("b_same_data", 32'(b_rd_data), 32'h5);

    // Random traffic with held pending requests.
    begin
      bit pend[NUM_REQ];
      int w;
      for (int i = 0; i < NUM_REQ; i++) pend[i] = 0;
      for (int cyc = 0; cyc < 600; cyc++) begin
        for (int i = 0; i < NUM_REQ; i++) begin
          if (!pend[i] && $urandom_range(0, 99) < 40) begin
            pend[i] = 1;
            m_if.wr_addr[i*AW +: AW] = AW'($urandom_range(0, NUM_REGS - 1));
            m_if.wr_data[i*DATA_W +: DATA_W] = DATA_W'($urandom_range(0, 15));
          end
          m_if.req[i] = pend[i];
        end
        clr_start = ($urandom_range(0, 99) < 3);
        rd_addr = AW'($urandom_range(0, NUM_REGS - 1));
        sample_check();
        w = model_winner();
        if (w >= 0) pend[w] = 0;
        advance();
      end
    end
    clr_start = 1'b0;
    m_if.req = '0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
